// File: rtl/mips8_io_arbiter.sv
// Round-robin owner arbitration for the shared user IO pad bank, with bounded hold
// time and a one-cycle safe turnaround between successive owners.
module mips8_io_arbiter #(
    parameter int NREQ     = 3,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 255
) (
    input  logic                                      wb_clk_i,
    input  logic                                      wb_rst_ni,
    input  logic [NREQ-1:0]                           req_i,
    input  logic [NREQ*WIDTH-1:0]                     out_i,
    input  logic [NREQ*WIDTH-1:0]                     oeb_i,
    output logic [NREQ-1:0]                           gnt_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner_o,
    output logic                                      busy_o,
    output logic                                      timeout_o,
    output logic [WIDTH-1:0]                          io_out,
    output logic [WIDTH-1:0]                          io_oeb
);

    // state   | meaning
    // S_IDLE  | no owner, pads safe, arbitrate on any request
    // S_GRANT | owner drives pads (one cycle behind its data), hold counter runs
    // S_TURN  | one safe cycle after release/preempt, then arbitrate as in IDLE

    localparam int              OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [OW:0]     NREQ_W   = (OW+1)'(NREQ);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [OW-1:0]     owner_r, rr_ptr, winner;
    logic [HW-1:0]     hold_cnt;
    logic              found, release_own, preempt, timeout_r;
    logic [2*NREQ-1:0] req_rot;
    logic [NREQ-1:0]   owner_hot;
    logic [WIDTH-1:0]  own_out, own_oeb, io_out_r, io_oeb_r;

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input logic [OW:0] inc);
        logic [OW:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        return sum[OW-1:0];
    endfunction

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        req_rot = {req_i, req_i} >> rr_ptr;
        found   = 1'b0;
        winner  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr, (OW+1)'(i));
            end
        end
    end

    always_comb begin
        owner_hot = NREQ'(1) << owner_r;
        own_out   = '0;
        own_oeb   = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_r == OW'(i)) begin
                own_out = out_i[i*WIDTH +: WIDTH];
                own_oeb = oeb_i[i*WIDTH +: WIDTH];
            end
        end
        release_own = ~|(req_i & owner_hot);
        preempt     = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) &&
                      (|(req_i & ~owner_hot)) && !release_own;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= S_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_TURN: state_nx = found ? S_GRANT : S_IDLE;
            S_GRANT:        if (release_own || preempt) state_nx = S_TURN;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Pads fall back to safe values on every edge that does not continue a grant,
    // so the release edge already blanks them for the TURN cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            owner_r   <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
            io_out_r  <= '0;
            io_oeb_r  <= '1;
        end else begin
            timeout_r <= 1'b0;
            io_out_r  <= '0;
            io_oeb_r  <= '1;
            case (state)
                S_GRANT: begin
                    if (release_own || preempt) begin
                        rr_ptr    <= wrap_add(owner_r, (OW+1)'(1));
                        timeout_r <= preempt;
                        hold_cnt  <= '0;
                    end else begin
                        io_out_r <= own_out;
                        io_oeb_r <= own_oeb;
                        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    if (found) begin
                        owner_r  <= winner;
                        hold_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy_o    = (state == S_GRANT);
        gnt_o     = busy_o ? owner_hot : '0;
        owner_o   = owner_r;
        timeout_o = timeout_r;
        io_out    = io_out_r;
        io_oeb    = io_oeb_r;
    end

endmodule

// File: tb/tb_mips8_io_arbiter.sv
// Directed bench for mips8_io_arbiter: reset, single grant, round robin,
// preemption/saturation, reset during a grant and pointer wrap.
module tb_mips8_io_arbiter;

    localparam int NREQ     = 3;
    localparam int WIDTH    = 16;
    localparam int MAX_HOLD = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] out_bus;
    logic [NREQ*WIDTH-1:0] oeb_bus;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic                  busy;
    logic                  timeout;
    logic [WIDTH-1:0]      io_out;
    logic [WIDTH-1:0]      io_oeb;

    int checks   = 0;
    int failures = 0;

    mips8_io_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .req_i     (req),
        .out_i     (out_bus),
        .oeb_i     (oeb_bus),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .busy_o    (busy),
        .timeout_o (timeout),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [15:0] o, input logic [15:0] e);
        out_bus[k*WIDTH +: WIDTH] = o;
        oeb_bus[k*WIDTH +: WIDTH] = e;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        step();
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b timeout=%b owner=%0d want 000/0/0/0", gnt, busy, timeout, owner);
        end
        checks++;
        if (io_oeb !== 16'hFFFF || io_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pads: io_oeb=%h io_out=%h want ffff/0000", io_oeb, io_out);
        end
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_src(0, 16'h1111, 16'h0000);
        set_src(1, 16'hA55A, 16'h0000);
        set_src(2, 16'h2222, 16'h0000);
        req = 3'b010;
        step();
        checks++;
        if (gnt !== 3'b010 || busy !== 1'b1 || owner !== 2'd1 || io_oeb !== 16'hFFFF) begin
            failures++;
            $display("FAIL single_grant: gnt=%b busy=%b owner=%0d io_oeb=%h want 010/1/1/ffff", gnt, busy, owner, io_oeb);
        end
        step();
        checks++;
        if (io_out !== 16'hA55A || io_oeb !== 16'h0000 || gnt !== 3'b010) begin
            failures++;
            $display("FAIL single_pads: io_out=%h io_oeb=%h gnt=%b want a55a/0000/010", io_out, io_oeb, gnt);
        end
        req = 3'b000;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || io_oeb !== 16'hFFFF || io_out !== 16'h0000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_release: gnt=%b busy=%b io_oeb=%h io_out=%h timeout=%b want 000/0/ffff/0000/0",
                     gnt, busy, io_oeb, io_out, timeout);
        end
        step();
    endtask

    task automatic test_round_robin();
        int         order[4] = '{0, 1, 2, 0};
        logic [2:0] exp_hot;
        logic [1:0] exp_own;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_src(k, 16'hC000 | 16'(k), 16'h0F00 | 16'(k));
        req = 3'b111;
        step();
        for (int r = 0; r < 4; r++) begin
            exp_own = 2'(order[r]);
            exp_hot = 3'b001 << exp_own;
            checks++;
            if (gnt !== exp_hot || owner !== exp_own) begin
                failures++;
                $display("FAIL rr_grant[%0d]: gnt=%b owner=%0d want %b/%0d", r, gnt, owner, exp_hot, exp_own);
            end
            for (int h = 0; h < 3; h++) begin
                step();
                checks++;
                if (gnt !== exp_hot || io_out !== (16'hC000 | 16'(exp_own)) || io_oeb !== (16'h0F00 | 16'(exp_own))) begin
                    failures++;
                    $display("FAIL rr_hold[%0d]: gnt=%b io_out=%h io_oeb=%h want %b/%h/%h", r, gnt, io_out, io_oeb,
                             exp_hot, 16'hC000 | 16'(exp_own), 16'h0F00 | 16'(exp_own));
                end
            end
            req = 3'b111 & ~exp_hot;
            step();
            checks++;
            if (gnt !== 3'b000 || busy !== 1'b0 || io_oeb !== 16'hFFFF || io_out !== 16'h0000) begin
                failures++;
                $display("FAIL rr_turn[%0d]: gnt=%b busy=%b io_oeb=%h io_out=%h want 000/0/ffff/0000",
                         r, gnt, busy, io_oeb, io_out);
            end
            req = 3'b111;
            step();
        end
        checks++;
        if (gnt !== 3'b010) begin
            failures++;
            $display("FAIL rr_next: gnt=%b want 010", gnt);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        set_src(0, 16'h0A0A, 16'h0000);
        set_src(2, 16'h5050, 16'h0000);
        req = 3'b001;
        step();
        checks++;
        if (gnt !== 3'b001) begin
            failures++;
            $display("FAIL pre_grant: gnt=%b want 001", gnt);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (timeout !== 1'b0 || gnt !== 3'b001) begin
                failures++;
                $display("FAIL pre_hold[%0d]: timeout=%b gnt=%b want 0/001", k, timeout, gnt);
            end
            if (k == 2) req = 3'b101;
        end
        step();
        checks++;
        if (timeout !== 1'b1 || gnt !== 3'b000 || busy !== 1'b0 || io_oeb !== 16'hFFFF) begin
            failures++;
            $display("FAIL pre_timeout: timeout=%b gnt=%b busy=%b io_oeb=%h want 1/000/0/ffff", timeout, gnt, busy, io_oeb);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || gnt !== 3'b100 || owner !== 2'd2) begin
            failures++;
            $display("FAIL pre_newowner: timeout=%b gnt=%b owner=%0d want 0/100/2", timeout, gnt, owner);
        end

        do_reset();
        req = 3'b001;
        step();
        for (int c = 1; c <= 100; c++) begin
            step();
            checks++;
            if (gnt !== 3'b001 || timeout !== 1'b0 || io_out !== 16'h0A0A) begin
                failures++;
                $display("FAIL solo_hold[%0d]: gnt=%b timeout=%b io_out=%h want 001/0/0a0a", c, gnt, timeout, io_out);
            end
        end
        req = 3'b101;
        step();
        checks++;
        if (timeout !== 1'b1 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL sat_preempt: timeout=%b gnt=%b want 1/000", timeout, gnt);
        end
        step();
        checks++;
        if (gnt !== 3'b100 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL sat_newowner: gnt=%b timeout=%b want 100/0", gnt, timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_src(1, 16'h00FF, 16'h0000);
        req = 3'b010;
        step();
        step();
        checks++;
        if (gnt !== 3'b010 || io_out !== 16'h00FF || io_oeb !== 16'h0000) begin
            failures++;
            $display("FAIL mid_drive: gnt=%b io_out=%h io_oeb=%h want 010/00ff/0000", gnt, io_out, io_oeb);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || io_oeb !== 16'hFFFF || io_out !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset: gnt=%b busy=%b io_oeb=%h io_out=%h want 000/0/ffff/0000", gnt, busy, io_oeb, io_out);
        end
        rst_n = 1'b1;
        req   = 3'b011;
        step();
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL mid_rrptr: gnt=%b owner=%0d want 001/0", gnt, owner);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_src(2, 16'hBEEF, 16'h0000);
        req = 3'b100;
        step();
        checks++;
        if (gnt !== 3'b100 || owner !== 2'd2) begin
            failures++;
            $display("FAIL wrap_grant: gnt=%b owner=%0d want 100/2", gnt, owner);
        end
        step();
        checks++;
        if (io_out !== 16'hBEEF || io_oeb !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_pads: io_out=%h io_oeb=%h want beef/0000", io_out, io_oeb);
        end
        req = 3'b001;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || io_oeb !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_turn: gnt=%b busy=%b io_oeb=%h want 000/0/ffff", gnt, busy, io_oeb);
        end
        step();
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL wrap_regrant: gnt=%b owner=%0d want 001/0", gnt, owner);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        out_bus = '0;
        oeb_bus = '1;
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
